sm_accumulator: RTL

//  Sequential sign-magnitude accumulator; sits directly downstream of the SM adder stage.

---
 rtl/sm_accumulator_if.sv | 23 ++
 rtl/sm_accumulator.sv | 96 +++++++++
 2 files changed

// File: rtl/sm_accumulator_if.sv
// sm_accumulator_if: start/operand handshake and result bus of the sign-magnitude accumulator.
interface sm_accumulator_if #(
    parameter int W = 5
);
    logic         start;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic [W-1:0] acc;
    logic         ovflw;
    logic         busy;
    logic         done;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, acc, ovflw, busy, done
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, acc, ovflw, busy, done
    );
endinterface

// File: rtl/sm_accumulator.sv
// sm_accumulator: sequential sign-magnitude accumulator over bursts of N_OPS operands.
// Build option SM_ACC_SAT_EN: when defined, a magnitude overflow saturates acc to the
// maximum magnitude; when undefined, the carry is dropped and the low bits are kept.
module sm_accumulator #(
    parameter int W     = 5,
    parameter int N_OPS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    sm_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

`ifdef SM_ACC_SAT_EN
    localparam logic LP_SAT = 1'b1;
`else
    localparam logic LP_SAT = 1'b0;
`endif
    localparam logic [7:0] LP_N = 8'(N_OPS);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_acc;
    logic         r_ovflw;
    logic [7:0]   r_count;

    logic [W-2:0] w_a_mag;
    logic [W-2:0] w_b_mag;
    logic         w_a_sgn;
    logic         w_b_sgn;
    logic [W-1:0] w_sum;
    logic         w_same;
    logic         w_a_ge;
    logic         w_ovf;
    logic [W-2:0] w_res_mag;
    logic         w_res_sgn;
    logic         w_accept;
    logic         w_start_ok;

    assign w_accept   = bus.in_valid && (r_state == ACCUM);
    assign w_start_ok = bus.start && (r_state != ACCUM);

    // Sign-magnitude add of the running total and the incoming operand; -0 is folded to +0.
    always_comb begin
        w_a_mag   = r_acc[W-2:0];
        w_b_mag   = bus.in_data[W-2:0];
        w_a_sgn   = r_acc[W-1] & (|w_a_mag);
        w_b_sgn   = bus.in_data[W-1] & (|w_b_mag);
        w_sum     = {1'b0, w_a_mag} + {1'b0, w_b_mag};
        w_same    = (w_a_sgn == w_b_sgn);
        w_a_ge    = (w_a_mag >= w_b_mag);
        w_ovf     = w_same & w_sum[W-1];
        w_res_mag = w_same ? ((w_ovf && LP_SAT) ? '1 : w_sum[W-2:0])
                           : (w_a_ge ? w_a_mag - w_b_mag : w_b_mag - w_a_mag);
        w_res_sgn = (|w_res_mag) & (w_same ? w_a_sgn : (w_a_ge ? w_a_sgn : w_b_sgn));
    end

    // Next-state: start is honoured only outside ACCUM; the N_OPS-th accept ends the burst.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: w_next = bus.start ? ACCUM : r_state;
            ACCUM:      w_next = (w_accept && (r_count + 8'd1 == LP_N)) ? DONE : ACCUM;
            default:    w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Datapath: an honoured start clears the burst, each accept folds one operand in.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_ovflw <= 1'b0;
            r_count <= '0;
        end else if (w_start_ok) begin
            r_acc   <= '0;
            r_ovflw <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_acc   <= {w_res_sgn, w_res_mag};
            r_ovflw <= r_ovflw | w_ovf;
            r_count <= r_count + 8'd1;
        end
    end

    assign bus.in_ready = (r_state == ACCUM);
    assign bus.busy     = (r_state == ACCUM);
    assign bus.done     = (r_state == DONE);
    assign bus.acc      = r_acc;
    assign bus.ovflw    = r_ovflw;
endmodule
